// File: rtl/rr_reg_arbiter_if.sv
// Bus bundle for rr_reg_arbiter: per-port request/lock/data in, shared register state out.
// The master side drives the requests; the slave side is the arbiter itself.
interface rr_reg_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = 2
);
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] din;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic [DW-1:0]   qn;
  logic [IW-1:0]   owner;
  logic            valid;
  logic            locked;

  modport master (
    output req, lock, din,
    input  gnt, q, qn, owner, valid, locked
  );

  modport slave (
    input  req, lock, din,
    output gnt, q, qn, owner, valid, locked
  );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among N requesters, with an
// optional per-port lock that lets the current owner keep exclusive write access.
module rr_reg_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rr_reg_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;

  logic            winFound;
  logic [IW-1:0]   winIdx;
  logic [IW:0]     candSum;
  logic [IW-1:0]   candIdx;
  logic            holdLock;

  // Search from ptr upward (mod N); the first requester found wins.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    candSum  = '0;
    candIdx  = '0;
    for (int k = 0; k < N; k++) begin
      candSum = {1'b0, ptr_q} + (IW+1)'(k);
      if (candSum >= (IW+1)'(N)) begin
        candSum = candSum - (IW+1)'(N);
      end
      candIdx = candSum[IW-1:0];
      if (!winFound && bus.req[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  assign holdLock = (state_q == LOCKED) && bus.lock[owner_q];

  // A held lock bypasses arbitration entirely; otherwise the winner is served.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_d   = '0;
    if (holdLock) begin
      state_d = LOCKED;
      if (bus.req[owner_q]) begin
        data_d         = bus.din[owner_q*DW +: DW];
        gnt_d[owner_q] = 1'b1;
      end
    end else if (winFound) begin
      data_d        = bus.din[winIdx*DW +: DW];
      gnt_d[winIdx] = 1'b1;
      owner_d       = winIdx;
      valid_d       = 1'b1;
      ptr_d         = (winIdx == IW'(N-1)) ? '0 : winIdx + 1'b1;
      state_d       = bus.lock[winIdx] ? LOCKED : IDLE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.q      = data_q;
  assign bus.qn     = ~data_q;
  assign bus.owner  = owner_q;
  assign bus.valid  = valid_q;
  assign bus.locked = (state_q == LOCKED);

endmodule
